// File: rtl/parity_scrub_pkg.sv
// Shared types for the parity scrub controller: arbiter FSM states and
// the source tag carried alongside each outstanding RAM read.
package parity_scrub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } scrub_state_t;

    typedef enum logic {
        SRC_USER  = 1'b0,
        SRC_SCRUB = 1'b1
    } read_src_t;

endpackage

// File: rtl/parity_scrub_ctrl_check.sv
// parity_check: even-parity check of a returned RAM word. err is high when
// the XOR of the data bits disagrees with the stored parity bit.
module parity_check #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic              parity,
    output logic              err
);

    assign err = ((^data) != parity);

endmodule

// File: rtl/parity_scrub_ctrl.sv
// parity_scrub_ctrl: shares one single-port parity-protected RAM between a
// user read port and a periodic background scrubber, checks parity on every
// returned word and logs scrub failures.
// Optional macro SCRUB_STARVE_GUARD_EN: adds the FORCE state and wait counter
// so a pending scrub cannot be starved by a continuous user request.
module parity_scrub_ctrl
    import parity_scrub_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int SCRUB_INTERVAL = 256,
    parameter int STARVE_LIMIT   = 16,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              user_req,
    input  logic [ADDR_W-1:0] user_addr,
    output logic              user_gnt,
    output logic              user_rvalid,
    output logic [DATA_W-1:0] user_rdata,
    output logic              user_perr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_parity,
    output logic              err_irq,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  err_count,
    input  logic              err_clr,
    output logic              sweep_done
);

    localparam int INT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    logic [INT_W-1:0]  int_cnt_reg;
    logic              expire;
    scrub_state_t      state_reg;
    scrub_state_t      state_next;
    logic              scrub_gnt;
    logic [ADDR_W-1:0] scrub_addr_reg;
    logic              tag_valid_reg;
    read_src_t         tag_src_reg;
    logic [ADDR_W-1:0] tag_addr_reg;
    logic              rd_err;
    logic              user_done;
    logic              scrub_fail;

    assign expire = (int_cnt_reg == INT_W'(SCRUB_INTERVAL - 1));

    // Free-running interval counter; restarts at once, independent of the grant
    always_ff @(posedge clk) begin
        if (reset || expire) begin
            int_cnt_reg <= '0;
        end else begin
            int_cnt_reg <= int_cnt_reg + 1'b1;
        end
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef SCRUB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] wait_reg;
    logic [WAIT_W-1:0] wait_next;

    // Starvation wait counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_reg <= '0;
        end else begin
            wait_reg <= wait_next;
        end
    end
`else
    // Strict user priority: the starvation limit has no effect in this build.
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

    // Next-state logic; an expiry while a scrub is already pending is dropped
    always_comb begin
        state_next = state_reg;
`ifdef SCRUB_STARVE_GUARD_EN
        wait_next  = wait_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (expire) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (!user_req) begin
                    state_next = IDLE;
`ifdef SCRUB_STARVE_GUARD_EN
                    wait_next  = '0;
                end else begin
                    wait_next = wait_reg + 1'b1;
                    if (wait_reg == WAIT_W'(STARVE_LIMIT - 1)) begin
                        state_next = FORCE;
                    end
`endif
                end
            end
            FORCE: begin
                state_next = IDLE;
`ifdef SCRUB_STARVE_GUARD_EN
                wait_next  = '0;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant decode; no read is accepted while reset is asserted
    always_comb begin
        user_gnt  = 1'b0;
        scrub_gnt = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE:    user_gnt = user_req;
                PEND: begin
                    user_gnt  = user_req;
                    scrub_gnt = !user_req;
                end
                FORCE:   scrub_gnt = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_rd_en  = user_gnt | scrub_gnt;
    assign mem_addr   = scrub_gnt ? scrub_addr_reg : (user_gnt ? user_addr : '0);
    assign sweep_done = scrub_gnt && (scrub_addr_reg == '1);

    // Scrub address walks the whole RAM and wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            scrub_addr_reg <= '0;
        end else if (scrub_gnt) begin
            scrub_addr_reg <= scrub_addr_reg + 1'b1;
        end
    end

    // One-entry tag: who issued the read now returning from the RAM
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_reg <= 1'b0;
            tag_src_reg   <= SRC_USER;
            tag_addr_reg  <= '0;
        end else begin
            tag_valid_reg <= mem_rd_en;
            tag_src_reg   <= scrub_gnt ? SRC_SCRUB : SRC_USER;
            tag_addr_reg  <= mem_addr;
        end
    end

    parity_check #(
        .DATA_W (DATA_W)
    ) u_parity_check (
        .data   (mem_rd_data),
        .parity (mem_rd_parity),
        .err    (rd_err)
    );

    assign user_done  = tag_valid_reg && (tag_src_reg == SRC_USER);
    assign scrub_fail = tag_valid_reg && (tag_src_reg == SRC_SCRUB) && rd_err;

    // User response register; scrub returns leave it untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            user_rvalid <= 1'b0;
            user_rdata  <= '0;
            user_perr   <= 1'b0;
        end else begin
            user_rvalid <= user_done;
            if (user_done) begin
                user_rdata <= mem_rd_data;
                user_perr  <= rd_err;
            end
        end
    end

    // Scrub error log; a failure arriving with err_clr restarts the log with it
    always_ff @(posedge clk) begin
        if (reset) begin
            err_irq   <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (scrub_fail) begin
            err_irq <= 1'b1;
            if (err_clr || (err_count == '0)) begin
                err_addr  <= tag_addr_reg;
                err_count <= CNT_W'(1);
            end else if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end else if (err_clr) begin
            err_irq   <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end
    end

endmodule

// File: doc/parity_scrub_ctrl.md
# parity_scrub_ctrl

Arbitrates one single-port, parity-protected synchronous RAM between a user read port and a background scrubber, and checks even parity on every returned word. The scrubber walks the whole address space at a fixed interval. Parity mismatches are reported to the user on user reads, and are logged (first failing address, saturating count, sticky interrupt) for scrub reads. The block sits between the RAM macro and the soft-error handling logic.

## Interface
- DATA_W, 32, RAM data width
- ADDR_W, 8, RAM address width; depth = 2^ADDR_W
- SCRUB_INTERVAL, 256, cycles between scrub read requests (≥2)
- STARVE_LIMIT, 16, cycles a pending scrub may wait before forcing a grant
- CNT_W, 8, width of the error counter
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- user_req  in  1  user read request
- user_addr  in  ADDR_W  user read address
- user_gnt  out  1  combinational; request accepted this cycle
- user_rvalid  out  1  registered; user read result valid
- user_rdata  out  DATA_W  user read data
- user_perr  out  1  parity error on user_rdata; qualified by user_rvalid
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM address
- mem_rd_data  in  DATA_W  RAM data, valid the cycle after mem_rd_en
- mem_rd_parity  in  1  stored even-parity bit for mem_rd_data
- err_irq  out  1  sticky; a scrub read has failed parity
- err_addr  out  ADDR_W  address of the first scrub failure since the last clear
- err_count  out  CNT_W  scrub failures since the last clear; saturates at all-ones
- err_clr  in  1  clears err_irq, err_addr and err_count
- sweep_done  out  1  one-cycle pulse when the scrub address wraps from 2^ADDR_W-1 to 0

## Operation
- Scrub timing:
  - The interval counter counts SCRUB_INTERVAL cycles, then sets scrub_pend.
  - The counter restarts immediately; it does not wait for the scrub grant.
  - If the counter expires again while scrub_pend is still set, the extra request is dropped.
- FSM states:
  - IDLE: scrub_pend=0.
  - PEND: scrub_pend=1, waiting for the RAM port.
  - FORCE: the wait counter has reached STARVE_LIMIT.
- Arbitration in PEND:
  - The user has priority; the wait counter increments on every cycle the user wins.
  - With no user request, the scrub is granted and the FSM goes to IDLE.
- Arbitration in FORCE:
  - The scrub is granted for exactly one cycle and user_gnt=0.
  - The FSM then goes to IDLE and the wait counter clears.
- Read pipeline:
  - A 1-entry tag register records source (user or scrub) and address for each issued read.
  - Calculated parity = XOR-reduction of mem_rd_data; an error is calculated parity ≠ mem_rd_parity.
  - A scrub read does not touch the user_* outputs.
- Scrub address: increments after each scrub grant and wraps to 0. sweep_done pulses on the grant at address 2^ADDR_W-1.
- Error logging:
  - On a failing scrub read: err_irq←1 and err_count saturating-increments.
  - err_addr is loaded only when err_count was 0.
  - err_clr in the same cycle as a failing scrub result: the result wins, leaving err_count=1, err_irq=1 and err_addr=the new address.
- Reset:
  - Clears all state, the scrub address and the tag register.
  - A read in flight when reset asserts is discarded; no user_rvalid is produced for it.
- Reset values: user_gnt=0, user_rvalid=0, user_rdata=0, user_perr=0, mem_rd_en=0, mem_addr=0, err_irq=0, err_addr=0, err_count=0, sweep_done=0.

## Timing
- Grant cycle N:
  - mem_rd_en=1 and mem_addr is driven in cycle N (combinational from the arbiter).
  - RAM data arrives in N+1.
  - user_rvalid, user_rdata and user_perr are registered and valid in N+2.
  - The error log updates at the N+2 edge (visible in N+2).
- Throughput: one read per cycle; back-to-back user reads are fully pipelined.
- Worst-case scrub delay from scrub_pend: STARVE_LIMIT+1 cycles.

## Configuration
- SCRUB_STARVE_GUARD_EN defined: FORCE state and wait counter present, as described above.
- Undefined: strict user priority, with no FORCE state and no wait counter; a continuous user_req starves the scrub indefinitely.

## Structure
- Package parity_scrub_pkg holds the FSM state enum (IDLE, PEND, FORCE) and the read-source tag enum (SRC_USER, SRC_SCRUB).
- One sub-module, parity_check: combinational XOR-reduction and compare, instantiated at the RAM return stage.

## Test plan
- Clean user read: user_req at addr 0x05, RAM returns 0x0000_0003 with parity 0 → user_rvalid two cycles after the grant, user_rdata=0x3, user_perr=0.
- Corrupted user read: data 0x0000_0001 with parity 0 → user_perr=1; err_irq stays 0 and err_count stays 0.
- Scrub error log:
  - Preload addr 0x10 with bad parity and let a sweep reach it → err_irq=1, err_addr=0x10, err_count=1.
  - A second bad address adds err_count=2 and leaves err_addr unchanged.
  - err_clr coincident with a third failure → err_count=1 and err_addr=the new address.
- Starvation with SCRUB_STARVE_GUARD_EN and user_req held high:
  - The scrub is granted exactly STARVE_LIMIT+1 cycles after scrub_pend.
  - user_gnt=0 in that cycle only.
  - Without the macro, no scrub grant occurs while user_req is held.
- Wrap: ADDR_W=2, SCRUB_INTERVAL=4, idle user → scrub addresses 0,1,2,3,0; sweep_done pulses once, on the address-3 grant.
- Reset mid-read: assert reset the cycle after a user grant → user_rvalid never asserts for it; all outputs take their reset values.
